// File: rtl/spi_boot_pkg.sv
//------------------------------------------------------------------------------
// Module   : spi_boot_pkg
// Purpose  : Shared FSM state encoding and SPI flash constants for the
//            SPI boot loader.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package spi_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAIL  = 3'd6
  } state_t;

  // Standard serial-flash READ opcode
  localparam logic [7:0] OPCODE_READ = 8'h03;
  // Erased flash reads back as all ones
  localparam logic [7:0] BLANK_BYTE  = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/spi_boot_shifter.sv
//------------------------------------------------------------------------------
// Module   : spi_boot_shifter
// Purpose  : SPI mode-0 byte engine. A go pulse shifts one byte out on MOSI
//            (MSB first) while capturing MISO on rising SCLK; done pulses
//            after the eighth falling edge. With tail=1 it only waits one
//            SCLK half-period with SCLK low (used to pad CS release).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_boot_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       tail,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             active;
  logic             tail_q;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sh;
  logic [7:0]       rx_sh;

  assign rx_byte = rx_sh;

  // Half-period divider, SCLK generation and the tx/rx shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      tail_q  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go && !active) begin
        active  <= 1'b1;
        tail_q  <= tail;
        div_cnt <= '0;
        bit_cnt <= '0;
        tx_sh   <= tx_byte;
        // First bit must be valid for a full low phase before the rising edge
        if (!tail) mosi <= tx_byte[7];
      end else if (active) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          if (tail_q) begin
            active <= 1'b0;
            done   <= 1'b1;
          end else if (!sclk) begin
            sclk  <= 1'b1;
            rx_sh <= {rx_sh[6:0], miso};
          end else begin
            sclk <= 1'b0;
            if (bit_cnt == 3'd7) begin
              active <= 1'b0;
              done   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx_sh   <= {tx_sh[6:0], 1'b0};
              mosi    <= tx_sh[6];
            end
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_boot_loader.sv
//------------------------------------------------------------------------------
// Module   : spi_boot_loader
// Purpose  : Copies a block of bytes from a SPI serial flash (READ 0x03) into
//            a 16-bit addressed memory through a mem_we/mem_ready handshake.
//            Optional feature macro SPI_BOOT_CHECKSUM_EN: one extra trailing
//            byte is read as an 8-bit checksum (data sum + checksum == 0).
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_boot_loader
  import spi_boot_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int LEN_W   = 16,
  parameter int CLK_DIV = 2
) (
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] flash_base,
  input  logic [LEN_W-1:0]  length,
  input  logic [15:0]       dest_base,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [15:0]       mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              fail
);

  localparam int ADDR_BYTES = ADDR_W / 8;

  state_t            state;
  logic              sh_go;
  logic              sh_tail;
  logic              sh_done;
  logic [7:0]        sh_tx;
  logic [7:0]        sh_rx;
  logic [ADDR_W-1:0] addr_sh;
  logic [2:0]        addr_left;
  logic [LEN_W-1:0]  remain;
  logic [15:0]       wr_addr;
  logic              first;
  logic              closing;
  logic              close_fail;
`ifdef SPI_BOOT_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  spi_boot_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk     (wb_clk_i),
    .rst_n   (rst_n),
    .go      (sh_go),
    .tail    (sh_tail),
    .tx_byte (sh_tx),
    .rx_byte (sh_rx),
    .done    (sh_done),
    .sclk    (spi_sclk),
    .mosi    (spi_mosi),
    .miso    (spi_miso)
  );

  // Transfer sequencing: command, address, data bytes, memory write handshake
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      spi_cs_n   <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      sh_go      <= 1'b0;
      sh_tail    <= 1'b0;
      sh_tx      <= '0;
      addr_sh    <= '0;
      addr_left  <= '0;
      remain     <= '0;
      wr_addr    <= '0;
      first      <= 1'b0;
      closing    <= 1'b0;
      close_fail <= 1'b0;
`ifdef SPI_BOOT_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      sh_go <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            done       <= 1'b0;
            fail       <= 1'b0;
            first      <= 1'b1;
            closing    <= 1'b0;
            close_fail <= 1'b0;
            remain     <= length;
            wr_addr    <= dest_base;
            addr_sh    <= flash_base;
`ifdef SPI_BOOT_CHECKSUM_EN
            csum       <= '0;
`endif
            if (length == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state    <= ST_CMD;
              spi_cs_n <= 1'b0;
              busy     <= 1'b1;
              sh_go    <= 1'b1;
              sh_tail  <= 1'b0;
              sh_tx    <= OPCODE_READ;
            end
          end
        end
        ST_CMD: begin
          if (sh_done) begin
            state     <= ST_ADDR;
            sh_tx     <= addr_sh[ADDR_W-1 -: 8];
            addr_sh   <= addr_sh << 8;
            addr_left <= 3'(ADDR_BYTES - 1);
            sh_go     <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (sh_done) begin
            sh_go <= 1'b1;
            if (addr_left == 3'd0) begin
              state <= ST_DATA;
              sh_tx <= 8'h00;
            end else begin
              sh_tx     <= addr_sh[ADDR_W-1 -: 8];
              addr_sh   <= addr_sh << 8;
              addr_left <= addr_left - 3'd1;
            end
          end
        end
        ST_DATA: begin
          if (sh_done) begin
            if (closing) begin
              // Trailing half-period elapsed: release CS and report
              spi_cs_n <= 1'b1;
              busy     <= 1'b0;
              closing  <= 1'b0;
              if (close_fail) begin
                state <= ST_FAIL;
                fail  <= 1'b1;
              end else begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end else if (first && sh_rx == BLANK_BYTE) begin
              closing    <= 1'b1;
              close_fail <= 1'b1;
              sh_go      <= 1'b1;
              sh_tail    <= 1'b1;
`ifdef SPI_BOOT_CHECKSUM_EN
            end else if (remain == '0) begin
              // Checksum byte: never written, only verified
              closing    <= 1'b1;
              close_fail <= ((csum + sh_rx) != 8'h00);
              sh_go      <= 1'b1;
              sh_tail    <= 1'b1;
`endif
            end else begin
              state     <= ST_WRITE;
              mem_we    <= 1'b1;
              mem_addr  <= wr_addr;
              mem_wdata <= sh_rx;
              wr_addr   <= wr_addr + 16'd1;
              remain    <= remain - 1'b1;
              first     <= 1'b0;
`ifdef SPI_BOOT_CHECKSUM_EN
              csum      <= csum + sh_rx;
`endif
            end
          end
        end
        ST_WRITE: begin
          // SCLK stays low here because the shifter is idle until sh_go
          if (mem_ready) begin
            mem_we <= 1'b0;
            state  <= ST_DATA;
            sh_go  <= 1'b1;
            sh_tx  <= 8'h00;
`ifdef SPI_BOOT_CHECKSUM_EN
            sh_tail <= 1'b0;
`else
            sh_tail    <= (remain == '0);
            closing    <= (remain == '0);
            close_fail <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_boot_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_spi_boot_loader
// Purpose  : Self-checking bench for spi_boot_loader with a behavioural SPI
//            flash, a memory responder and a transfer-level reference model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_boot_loader;

  localparam int CLK_DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] flash_base;
  logic [15:0] length;
  logic [15:0] dest_base;
  logic        spi_cs_n, spi_sclk, spi_mosi;
  logic        spi_miso;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_ready;
  logic        busy, done, fail;

  int total = 0;
  int bad   = 0;

  spi_boot_loader #(.ADDR_W(24), .LEN_W(16), .CLK_DIV(CLK_DIV)) dut (
    .wb_clk_i   (clk),
    .rst_n      (rst_n),
    .start      (start),
    .flash_base (flash_base),
    .length     (length),
    .dest_base  (dest_base),
    .spi_cs_n   (spi_cs_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .done       (done),
    .fail       (fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural SPI flash ----------------
  logic [7:0]  flash [int unsigned];
  logic [31:0] cmd_word = '0;
  int          nbits = 0;
  int          fm_j;
  logic [7:0]  fm_b;

  function automatic logic [7:0] flash_rd(input int unsigned a);
    int unsigned m;
    m = a & 32'h00FF_FFFF;
    if (flash.exists(m)) return flash[m];
    return 8'(m) ^ 8'h5A;
  endfunction

  initial forever begin
    @(posedge spi_sclk);
    if (!spi_cs_n) begin
      if (nbits < 32) cmd_word = {cmd_word[30:0], spi_mosi};
      nbits++;
    end
  end

  initial forever begin
    @(negedge spi_sclk);
    if (!spi_cs_n && nbits >= 32) begin
      fm_j = nbits - 32;
      fm_b = flash_rd(cmd_word[23:0] + fm_j / 8);
      spi_miso = fm_b[7 - (fm_j % 8)];
    end
  end

  initial forever begin
    @(posedge spi_cs_n);
    nbits = 0;
  end

  // ---------------- memory responder and monitors ----------------
  logic [23:0] wq[$];
  int ready_delay = 0;
  int wait_cnt = 0;
  int stall_run = 0;
  int stall_max = 0;
  int sclk_bad = 0;
  int cs_low_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (mem_we) begin
      wait_cnt++;
      mem_ready = (wait_cnt > ready_delay);
    end else begin
      wait_cnt = 0;
      mem_ready = 1'b0;
    end
    if (mem_we && !mem_ready) begin
      stall_run++;
      if (stall_run > stall_max) stall_max = stall_run;
      if (spi_sclk) sclk_bad++;
    end else begin
      stall_run = 0;
    end
    if (!spi_cs_n) cs_low_cnt++;
  end

  initial forever begin
    @(posedge clk);
    if (rst_n && mem_we && mem_ready) wq.push_back({mem_addr, mem_wdata});
  end

  // ---------------- transfer helpers ----------------
  task automatic run_copy(input logic [23:0] base, input logic [15:0] len,
                          input logic [15:0] dest, output int cycles);
    @(negedge clk);
    flash_base = base;
    length     = len;
    dest_base  = dest;
    start      = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    while (!(done || fail) && cycles < 20000) begin
      @(negedge clk);
      cycles++;
    end
    chk("timeout", 64'(cycles < 20000), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  // Reference: bytes come from consecutive (wrapping) flash addresses and land
  // at consecutive (wrapping) destination addresses; a blank first byte aborts.
  task automatic check_copy(input string tag, input logic [23:0] base,
                            input logic [15:0] len, input logic [15:0] dest,
                            output int cycles);
    logic [23:0] exp_q[$];
    logic        exp_fail;
    logic [7:0]  b;
    logic [7:0]  sum;
    exp_fail = 1'b0;
    sum      = 8'h00;
    for (int i = 0; i < int'(len); i++) begin
      b = flash_rd(base + i);
      if (i == 0 && b == 8'hFF) begin
        exp_fail = 1'b1;
        break;
      end
      sum = sum + b;
      exp_q.push_back({dest + 16'(i), b});
    end
`ifdef SPI_BOOT_CHECKSUM_EN
    if (!exp_fail && len != 16'd0) begin
      b = flash_rd(base + len);
      if (8'(sum + b) != 8'h00) exp_fail = 1'b1;
    end
`endif
    wq.delete();
    run_copy(base, len, dest, cycles);
    chk({tag, "/nwr"}, 64'(wq.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
      chk($sformatf("%s/wr%0d", tag, i), 64'(wq[i]), 64'(exp_q[i]));
    chk({tag, "/done"}, 64'(done), 64'(!exp_fail));
    chk({tag, "/fail"}, 64'(fail), 64'(exp_fail));
    chk({tag, "/cs_n"}, 64'(spi_cs_n), 64'd1);
    chk({tag, "/busy"}, 64'(busy), 64'd0);
    if (len != 16'd0) chk({tag, "/cmd"}, 64'(cmd_word), 64'({8'h03, base}));
  endtask

  // ---------------- main sequence ----------------
  int cyc;
  int n0;
  int guard;

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    flash_base = '0;
    length     = '0;
    dest_base  = '0;
    spi_miso   = 1'b0;
    mem_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 64'(spi_cs_n), 64'd1);
    chk("rst_outs", 64'({spi_sclk, spi_mosi, mem_we, busy, done, fail}), 64'd0);
    chk("rst_mem", 64'({mem_addr, mem_wdata}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed copy crossing a 0x2000 destination boundary
    flash[32'h100] = 8'h12;
    flash[32'h101] = 8'h34;
    flash[32'h102] = 8'hA5;
    flash[32'h103] = 8'h15;
    check_copy("basic", 24'h000100, 16'd3, 16'h1FFE, cyc);
    chk("basic_cmd", 64'(cmd_word), 64'h0300_0100);

    // Slow memory: 20 stalled cycles per byte
    ready_delay = 20;
    stall_max   = 0;
    sclk_bad    = 0;
    check_copy("slow", 24'h000100, 16'd3, 16'h0040, cyc);
    chk("slow_stall", 64'(stall_max), 64'd20);
    chk("slow_sclk", 64'(sclk_bad), 64'd0);
    ready_delay = 0;

    // Blank flash
    flash[32'h200] = 8'hFF;
    flash[32'h201] = 8'h11;
    check_copy("blank", 24'h000200, 16'd2, 16'h4000, cyc);

    // Zero length
    cs_low_cnt = 0;
    check_copy("zero", 24'h000100, 16'd0, 16'h5000, cyc);
    chk("zero_lat", 64'(cyc <= 2), 64'd1);
    chk("zero_cs", 64'(cs_low_cnt), 64'd0);

    // Reset during the second data byte, then a clean copy
    for (int i = 0; i < 5; i++) flash[32'h300 + i] = 8'(8'h40 + i * 7);
    wq.delete();
    @(negedge clk);
    flash_base = 24'h000300;
    length     = 16'd4;
    dest_base  = 16'h0800;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (nbits < 32 + 8 + 3 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_reach", 64'(guard < 5000), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", 64'(spi_cs_n), 64'd1);
    chk("midrst_we", 64'(mem_we), 64'd0);
    n0 = wq.size();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("midrst_nowr", 64'(wq.size()), 64'(n0));
    chk("midrst_idle", 64'({busy, done, fail, spi_cs_n}), 64'b0001);
    check_copy("after_rst", 24'h000300, 16'd4, 16'h0800, cyc);

`ifdef SPI_BOOT_CHECKSUM_EN
    flash[32'h500] = 8'h01;
    flash[32'h501] = 8'h02;
    flash[32'h502] = 8'hFD;
    check_copy("csum_ok", 24'h000500, 16'd2, 16'h0010, cyc);
    flash[32'h502] = 8'hFC;
    check_copy("csum_bad", 24'h000500, 16'd2, 16'h0010, cyc);
`endif

    // Randomised copies including flash and destination wrap
    for (int t = 0; t < 10; t++) begin
      logic [23:0] base;
      logic [15:0] len;
      logic [15:0] dest;
      logic [7:0]  s;
      base = ($urandom_range(0, 2) == 0) ? 24'(24'hFFFFFF - $urandom_range(0, 3))
                                         : 24'($urandom);
      len  = 16'($urandom_range(1, 6));
      dest = ($urandom_range(0, 2) == 0) ? 16'hFFFD : 16'($urandom);
      ready_delay = $urandom_range(0, 3);
      s = 8'h00;
      for (int i = 0; i < int'(len); i++) begin
        flash[(base + i) & 32'h00FF_FFFF] = 8'($urandom);
        s = s + flash[(base + i) & 32'h00FF_FFFF];
      end
      if ($urandom_range(0, 4) == 0) flash[32'(base)] = 8'hFF;
      flash[(base + len) & 32'h00FF_FFFF] = ($urandom_range(0, 1) == 0) ? 8'(-s) : 8'($urandom);
      check_copy($sformatf("rnd%0d", t), base, len, dest, cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
